// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion sequencer.
package sar_pkg;

    localparam int unsigned SAR_NBITS_DEF = 8;
    localparam int unsigned SAMPLE_W      = 8;
    localparam int unsigned SETTLE_W      = 6;
    localparam int unsigned CNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        TRIAL  = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

    // Phase length of N cycles (0 meaning 1) becomes a down-counter preload of N-1.
    function automatic logic [CNT_W-1:0] cyc_to_load(input logic [CNT_W-1:0] cyc);
        return (cyc == '0) ? '0 : cyc - CNT_W'(1);
    endfunction

endpackage

// File: rtl/sar_cnt.sv
// Loadable down-counter with zero flag; times both the sample and settle phases.
module sar_cnt
    import sar_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/sar_sequencer.sv
// Successive-approximation ADC sequencer: sample, NBITS binary-search trials, done pulse.
// Define SAR_CONT_EN to add the cont input for back-to-back continuous conversions.
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int unsigned NBITS = SAR_NBITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] sample_cyc,
    input  logic [SETTLE_W-1:0] settle_cyc,
    input  logic                comp_in,
`ifdef SAR_CONT_EN
    input  logic                cont,
`endif
    output logic                sample_en,
    output logic [NBITS-1:0]    dac_code,
    output logic                busy,
    output logic                done,
    output logic [NBITS-1:0]    result
);

    localparam int unsigned IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    sar_state_t          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [SETTLE_W-1:0] r_settle;

    logic                w_cont;
    logic                w_restart;
    logic                w_cnt_load;
    logic [CNT_W-1:0]    w_cnt_val;
    logic                w_cnt_zero;
    logic [NBITS-1:0]    w_bit;
    logic [NBITS-1:0]    w_kept;
    logic [NBITS-1:0]    w_next_bit;

`ifdef SAR_CONT_EN
    assign w_cont = cont;
`else
    assign w_cont = 1'b0;
`endif

    // Comparator high means the trial level overshoots the held input: drop that bit.
    assign w_bit      = NBITS'(1) << r_idx;
    assign w_kept     = comp_in ? (dac_code & ~w_bit) : dac_code;
    assign w_next_bit = NBITS'(1) << (r_idx - IDX_W'(1));
    assign w_restart  = ((r_state == IDLE) && start) || ((r_state == DONE) && w_cont);

    // The sample length is loaded straight into the counter on accept, so it acts as the latched copy.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = cyc_to_load(sample_cyc);
        if (w_restart) begin
            w_cnt_load = 1'b1;
        end else if (w_cnt_zero &&
                     ((r_state == SAMPLE) || ((r_state == TRIAL) && (r_idx != '0)))) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = cyc_to_load(CNT_W'(r_settle));
        end
    end

    sar_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_zero_c   (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_settle  <= '0;
            sample_en <= 1'b0;
            dac_code  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_settle  <= settle_cyc;
                        r_state   <= SAMPLE;
                        sample_en <= 1'b1;
                        busy      <= 1'b1;
                        dac_code  <= '0;
                    end
                end
                SAMPLE: begin
                    if (w_cnt_zero) begin
                        r_state   <= TRIAL;
                        sample_en <= 1'b0;
                        r_idx     <= IDX_W'(NBITS - 1);
                        dac_code  <= {1'b1, {(NBITS-1){1'b0}}};
                    end
                end
                TRIAL: begin
                    if (w_cnt_zero) begin
                        if (r_idx == '0) begin
                            r_state  <= DONE;
                            done     <= 1'b1;
                            result   <= w_kept;
                            dac_code <= w_kept;
                        end else begin
                            r_idx    <= r_idx - IDX_W'(1);
                            dac_code <= w_kept | w_next_bit;
                        end
                    end
                end
                DONE: begin
                    if (w_cont) begin
                        r_settle  <= settle_cyc;
                        r_state   <= SAMPLE;
                        sample_en <= 1'b1;
                        dac_code  <= '0;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_sequencer.sv
// Scoreboard bench for sar_sequencer: random conversions against an ideal-converter model.
module tb_sar_sequencer;

    localparam int unsigned NB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    sample_cyc;
    logic [5:0]    settle_cyc;
    logic          comp_in;
`ifdef SAR_CONT_EN
    logic          cont;
`endif
    logic          sample_en;
    logic          busy;
    logic          done;
    logic [NB-1:0] dac_code;
    logic [NB-1:0] result;

    logic [NB-1:0] vin;
    int            mode;

    typedef struct {
        int res;
        int cyc;
        int samp;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   samp_cnt = 0;
    int   last_done_cyc = -1;
    logic prev_done = 1'b0;

    sar_sequencer #(.NBITS(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sample_cyc (sample_cyc),
        .settle_cyc (settle_cyc),
        .comp_in    (comp_in),
`ifdef SAR_CONT_EN
        .cont       (cont),
`endif
        .sample_en  (sample_en),
        .dac_code   (dac_code),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator: mode 0 = ideal against vin, 1 = stuck low, 2 = stuck high.
    assign comp_in = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (dac_code > vin);

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    // An ideal SAR settles on the largest code not above the input.
    function automatic int ref_result(input int v, input int m);
        if (m == 1) return (1 << NB) - 1;
        if (m == 2) return 0;
        return v % (1 << NB);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            samp_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (sample_en) begin
                samp_cnt++;
                chk("dac_zero_in_sample", int'(dac_code), 0);
            end
            if (!busy) begin
                chk("idle_sample_en", int'(sample_en), 0);
                chk("idle_dac_holds_result", int'(dac_code), int'(result));
            end
            if (done) begin
                chk("done_width", int'(prev_done), 0);
                last_done_cyc = cyc;
                if (q.size() == 0) begin
                    chk("done_with_empty_scoreboard", q.size(), 1);
                end else begin
                    m_e = q.pop_front();
                    chk("result", int'(result), m_e.res);
                    chk("done_cycle", cyc, m_e.cyc);
                    chk("sample_len", samp_cnt, m_e.samp);
                end
                samp_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy || q.size() != 0) begin
            chk("idle_timeout", int'(busy) + q.size(), 0);
            q.delete();
        end
    endtask

    task automatic issue(input int v, input int m, input int s, input int t,
                         input bit perturb, output int c);
        exp_t e;
        @(posedge clk); #1;
        vin        = NB'(v);
        mode       = m;
        sample_cyc = 8'(s);
        settle_cyc = 6'(t);
        start      = 1'b1;
        c          = cyc;
        e.res  = ref_result(v, m);
        e.cyc  = c + 1 + eff(s) + int'(NB) * eff(t);
        e.samp = eff(s);
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        if (perturb) begin
            for (int i = 0; i < eff(s) + int'(NB) * eff(t) - 1; i++) begin
                start      = 1'($urandom % 2);
                sample_cyc = 8'($urandom);
                settle_cyc = 6'($urandom);
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
    endtask

    task automatic convert(input int v, input int m, input int s, input int t,
                           input bit perturb, output int c);
        issue(v, m, s, t, perturb, c);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        exp_t e;
        rst = 1'b1; start = 1'b0; sample_cyc = '0; settle_cyc = '0;
        vin = '0;  mode = 0;
`ifdef SAR_CONT_EN
        cont = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sample_en", int'(sample_en), 0);
        chk("rst_dac_code",  int'(dac_code), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_done",      int'(done), 0);
        chk("rst_result",    int'(result), 0);

        convert(8'hA5, 0, 2, 3, 1'b0, c);
        chk("latency_a5", last_done_cyc - c, 27);
        convert($urandom % 256, 1, 1, 1, 1'b0, c);
        convert($urandom % 256, 2, 3, 2, 1'b0, c);
        convert(8'h5A, 0, 0, 0, 1'b0, c);
        chk("latency_zero_cfg", last_done_cyc - c, 10);

        // Abort during the trial of bit 4.
        issue(8'h77, 0, 2, 3, 1'b0, c);
        repeat (11) @(posedge clk);
        #1;
        chk("busy_before_reset", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_busy",      int'(busy), 0);
        chk("abort_done",      int'(done), 0);
        chk("abort_dac_code",  int'(dac_code), 0);
        chk("abort_result",    int'(result), 0);
        chk("abort_sample_en", int'(sample_en), 0);
        convert(8'h3C, 0, 2, 3, 1'b0, c);

        convert(8'hC3, 0, 3, 2, 1'b1, c);
        chk("latency_perturbed", last_done_cyc - c, 1 + 3 + 8 * 2);

        for (int k = 0; k < 20; k++) begin
            convert($urandom % 256, $urandom % 3, $urandom % 6, $urandom % 5,
                    1'($urandom % 2), c);
        end

`ifdef SAR_CONT_EN
        cont = 1'b1;
        issue(8'h96, 0, 1, 2, 1'b0, c);
        e = q[0];
        for (int k = 1; k < 3; k++) begin
            e.cyc = e.cyc + 1 + 1 + int'(NB) * 2;
            q.push_back(e);
        end
        for (int n = 0; n < 200 && q.size() > 1; n++) @(negedge clk);
        @(posedge clk); #1;
        cont = 1'b0;
        wait_idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
